// File: rtl/el_correlator_energy_if.sv
// el_correlator_energy_if: sample/chip/dump inputs and energy outputs of the correlator (pp only with CORR_PROMPT_EN)
interface el_correlator_energy_if #(
  parameter int SAMPLE_W = 8
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [SAMPLE_W-1:0] q_sample;
  logic                       code_e;
  logic                       code_p;
  logic                       code_l;
  logic                       dump;
  logic signed [63:0]         pe;
  logic signed [63:0]         pl;
`ifdef CORR_PROMPT_EN
  logic signed [63:0]         pp;
`endif
  logic                       energy_valid;
  logic                       busy;
  logic                       overrun;
  modport master (
    output sample_valid, i_sample, q_sample, code_e, code_p, code_l, dump,
    input `ifdef CORR_PROMPT_EN pp, `endif pe, pl, energy_valid, busy, overrun
  );
  modport slave (
    input sample_valid, i_sample, q_sample, code_e, code_p, code_l, dump,
    output `ifdef CORR_PROMPT_EN pp, `endif pe, pl, energy_valid, busy, overrun
  );
endinterface

// File: rtl/el_correlator_energy.sv
// el_correlator_energy: E/L integrate-and-dump correlator with one time-shared squarer; CORR_PROMPT_EN adds the prompt arm
module el_correlator_energy #(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 32
) (
  input logic                   clk,
  input logic                   rst,
  el_correlator_energy_if.slave s
);
`ifdef CORR_PROMPT_EN
  localparam int NA = 6;
  localparam int SW = 3;
`else
  localparam int NA = 4;
  localparam int SW = 2;
`endif
  typedef enum logic [1:0] {IDLE, SQ, OUT} state_t;
  state_t                     state_q, state_d;
  logic [SW-1:0]              step_q, step_d;
  logic signed [ACC_W-1:0]    acc_q [NA];
  logic signed [ACC_W-1:0]    acc_n [NA];
  logic signed [ACC_W-1:0]    snap_q [NA];
  logic [63:0]                sum_q [NA/2];
  logic [63:0]                pe_q, pl_q;
  logic                       ev_q, ov_q;
  logic [NA/2-1:0]            code;
  logic signed [SAMPLE_W-1:0] i_s, q_s;
  logic signed [2*ACC_W-1:0]  prod;
  logic [63:0]                add, sat;
  assign i_s = s.i_sample;
  assign q_s = s.q_sample;
`ifdef CORR_PROMPT_EN
  logic [63:0] pp_q;
  assign code = {s.code_p, s.code_l, s.code_e};
  assign s.pp = pp_q;
`else
  assign code = {s.code_l, s.code_e};
`endif
  // Accumulator order E_I, E_Q, L_I, L_Q, P_I, P_Q matches the squaring step order
  for (genvar g = 0; g < NA; g++) begin : arm
    logic signed [ACC_W-1:0] x;
    assign x = ACC_W'(g % 2 ? q_s : i_s);
    assign acc_n[g] = acc_q[g] + (s.sample_valid ? (code[g/2] ? x : -x) : '0);
  end
  // Squares are non-negative and below 2^63, so bit 63 of the sum flags overflow
  assign prod = snap_q[step_q] * snap_q[step_q];
  assign add  = sum_q[step_q[SW-1:1]] + 64'(prod);
  assign sat  = add[63] ? {1'b0, {63{1'b1}}} : add;
  always_comb begin
    state_d = state_q == IDLE ? (s.dump ? SQ : IDLE) :
              state_q == SQ   ? (step_q == SW'(NA-1) ? OUT : SQ) : IDLE;
    step_d  = state_q == SQ ? step_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      pe_q    <= '0;
      pl_q    <= '0;
`ifdef CORR_PROMPT_EN
      pp_q    <= '0;
`endif
      ev_q    <= 1'b0;
      ov_q    <= 1'b0;
      for (int k = 0; k < NA; k++) acc_q[k] <= '0;
      for (int k = 0; k < NA; k++) snap_q[k] <= '0;
      for (int k = 0; k < NA/2; k++) sum_q[k] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ev_q    <= state_q == OUT;
      ov_q    <= ov_q | (s.dump && state_q != IDLE);
      for (int k = 0; k < NA; k++) acc_q[k] <= s.dump ? '0 : acc_n[k];
      if (state_q == IDLE && s.dump) begin
        for (int k = 0; k < NA; k++) snap_q[k] <= acc_n[k];
        for (int k = 0; k < NA/2; k++) sum_q[k] <= '0;
      end
      if (state_q == SQ) sum_q[step_q[SW-1:1]] <= sat;
      if (state_q == OUT) begin
        pe_q <= sum_q[0];
        pl_q <= sum_q[1];
`ifdef CORR_PROMPT_EN
        pp_q <= sum_q[2];
`endif
      end
    end
  end
  assign s.pe           = pe_q;
  assign s.pl           = pl_q;
  assign s.energy_valid = ev_q;
  assign s.busy         = state_q != IDLE;
  assign s.overrun      = ov_q;
endmodule

// File: tb/tb_el_correlator_energy.sv
// tb_el_correlator_energy: directed stimulus with a queued scoreboard checked by per-DUT monitors
module tb_el_correlator_energy;
`ifdef CORR_PROMPT_EN
  localparam int N = 6;
`else
  localparam int N = 4;
`endif
  typedef struct {
    logic [63:0] pe;
    logic [63:0] pl;
    logic [63:0] pp;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  el_correlator_energy_if #(.SAMPLE_W(8)) a ();
  el_correlator_energy_if #(.SAMPLE_W(8)) b ();
  el_correlator_energy #(.SAMPLE_W(8), .ACC_W(32)) dut_a (.clk(clk), .rst(rst), .s(a));
  el_correlator_energy #(.SAMPLE_W(8), .ACC_W(8))  dut_b (.clk(clk), .rst(rst), .s(b));
  always @(negedge clk) begin
    if (!rst && a.energy_valid) begin
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_valid at cycle %0d pe=%0d pl=%0d", cyc, a.pe, a.pl);
      end else begin
        ea = qa.pop_front();
        checks++;
        if (a.pe !== ea.pe || a.pl !== ea.pl || cyc != ea.cyc
`ifdef CORR_PROMPT_EN
            || a.pp !== ea.pp
`endif
           ) begin
          errors++;
          $display("FAIL a_energy got pe=%0d pl=%0d cyc=%0d exp pe=%0d pl=%0d cyc=%0d",
                   a.pe, a.pl, cyc, ea.pe, ea.pl, ea.cyc);
`ifdef CORR_PROMPT_EN
          $display("FAIL a_energy_pp got %0d exp %0d", a.pp, ea.pp);
`endif
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && b.energy_valid) begin
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_valid at cycle %0d pe=%0d", cyc, b.pe);
      end else begin
        eb = qb.pop_front();
        checks++;
        if (b.pe !== eb.pe || b.pl !== eb.pl || cyc != eb.cyc) begin
          errors++;
          $display("FAIL b_extreme got pe=%0d pl=%0d cyc=%0d exp pe=%0d pl=%0d cyc=%0d",
                   b.pe, b.pl, cyc, eb.pe, eb.pl, eb.cyc);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", n, act, exp);
    end
  endtask
  // c = {code_l, code_p, code_e}
  task automatic drive(input logic v, input int i, input int q, input logic [2:0] c, input logic d);
    @(negedge clk);
    a.sample_valid = v;
    a.i_sample     = 8'(i);
    a.q_sample     = 8'(q);
    a.code_e       = c[0];
    a.code_p       = c[1];
    a.code_l       = c[2];
    a.dump         = d;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 3'b000, 1'b0);
  endtask
  task automatic expect_a(input longint e, input longint l, input longint p);
    qa.push_back('{pe: 64'(e), pl: 64'(l), pp: 64'(p), cyc: cyc + N + 2});
  endtask
  initial begin
    {a.sample_valid, a.i_sample, a.q_sample, a.code_e, a.code_p, a.code_l, a.dump} = '0;
    {b.sample_valid, b.i_sample, b.q_sample, b.code_e, b.code_p, b.code_l, b.dump} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_pe", a.pe, 0);
    chk("reset_pl", a.pl, 0);
    chk("reset_valid", 64'(a.energy_valid), 0);
    chk("reset_busy", 64'(a.busy), 0);
    chk("reset_overrun", 64'(a.overrun), 0);
    // -128 on both E arms of the narrow build; L arm negates to +128 which wraps back to -128
    @(negedge clk);
    b.sample_valid = 1'b1; b.i_sample = -8'sd128; b.q_sample = -8'sd128; b.code_e = 1'b1;
    @(negedge clk);
    b.sample_valid = 1'b0; b.dump = 1'b1;
    qb.push_back('{pe: 64'd32768, pl: 64'd32768, pp: 64'd32768, cyc: cyc + N + 2});
    @(negedge clk);
    b.dump = 1'b0;
    // Known correlation: E_I=30, E_Q=-20, L_I=-30, L_Q=20
    repeat (10) drive(1'b1, 3, -2, 3'b001, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(1300, 1300, 1300);
    idle(N + 3);
    // Split epoch: alternating chips cancel
    for (int k = 0; k < 8; k++) drive(1'b1, 5, 0, k % 2 ? 3'b000 : 3'b111, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(0, 0, 0);
    idle(N + 3);
    for (int k = 0; k < 8; k++) drive(1'b1, 5, 0, k % 2 ? 3'b000 : 3'b111, 1'b0);
    drive(1'b1, 4, 0, 3'b111, 1'b1);
    expect_a(16, 16, 16);
    idle(N + 3);
    drive(1'b1, 1, 0, 3'b111, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(1, 1, 1);
    idle(N + 3);
    // Overrun: second dump two cycles after the first
    chk("overrun_before", 64'(a.overrun), 0);
    repeat (2) drive(1'b1, 1, 1, 3'b101, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(8, 8, 8);
    drive(1'b1, 10, 0, 3'b101, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    idle(1);
    chk("overrun_busy", 64'(a.busy), 1);
    chk("overrun_set", 64'(a.overrun), 1);
    idle(N + 6);
    chk("overrun_held", 64'(a.overrun), 1);
    chk("overrun_pe_hold", a.pe, 8);
    drive(1'b1, 2, 0, 3'b101, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(4, 4, 4);
    idle(N + 3);
    // Prompt arm: 4 samples i=q=7 on every code
    repeat (4) drive(1'b1, 7, 7, 3'b111, 1'b0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(1568, 1568, 1568);
    idle(N + 3);
    chk("overrun_still", 64'(a.overrun), 1);
    // Reset mid-accumulation with a result still pending
    repeat (3) drive(1'b1, 9, 9, 3'b111, 1'b0);
    drive(1'b1, 9, 9, 3'b111, 1'b1);
    drive(1'b1, 9, 9, 3'b111, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_pe", a.pe, 0);
    chk("rst_pl", a.pl, 0);
    chk("rst_busy", 64'(a.busy), 0);
    chk("rst_overrun", 64'(a.overrun), 0);
    idle(N + 4);
    chk("rst_no_valid_pe", a.pe, 0);
    drive(1'b0, 0, 0, 3'b000, 1'b1);
    expect_a(0, 0, 0);
    idle(N + 6);
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d exp 0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
